nios_leds_ctrl: RTL and testbench



---
 rtl/nios_leds_pkg.sv | 14 +
 rtl/nios_leds_blink.sv | 42 ++++
 rtl/nios_leds_ctrl.sv | 103 ++++++++++
 tb/tb_nios_leds_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_leds_pkg.sv
// Shared register map and STATUS bit layout for the nios_leds_ctrl slave.
package nios_leds_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE   = 0;
    localparam int STATUS_RUNNING = 1;

endpackage

// File: rtl/nios_leds_blink.sv
// Blink half-period counter and phase register.
module nios_leds_blink #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // A PERIOD write restarts the engine even on a wrap cycle
        if (period_wr || period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/nios_leds_ctrl.sv
// Avalon-MM LED controller with set/clear registers and optional blink.
// Blink engine, MODE, PERIOD and STATUS exist only with NIOS_LEDS_BLINK_EN.
module nios_leds_ctrl
    import nios_leds_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               PERIOD_W    = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unused_bits;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];
    assign unused_bits = ^{writedata, PERIOD_W[0]};

    always_comb begin
        data_d = data_q;
        unique case (1'b1)
            wr && address == ADDR_DATA:     data_d = wd;
            wr && address == ADDR_OUTSET:   data_d = data_q | wd;
            wr && address == ADDR_OUTCLEAR: data_d = data_q & ~wd;
            default:                        data_d = data_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= RESET_VALUE;
        else       data_q <= data_d;
    end

`ifdef NIOS_LEDS_BLINK_EN
    logic [WIDTH-1:0]    mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr && address == ADDR_PERIOD;

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        if (wr && address == ADDR_MODE) mode_d = wd;
        if (period_wr) period_d = writedata[PERIOD_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            period_q <= '0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
        end
    end

    nios_leds_blink #(
        .PERIOD_W (PERIOD_W)
    ) u_blink (
        .clk       (clk),
        .reset     (reset),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]    = data_q;
            ADDR_MODE:   readdata[WIDTH-1:0]    = mode_q;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE]   = phase;
                readdata[STATUS_RUNNING] = period_q != '0;
            end
            default:     readdata = '0;
        endcase
    end

    assign out_port = data_q & (~mode_q | {WIDTH{phase}});
`else
    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA) readdata[WIDTH-1:0] = data_q;
    end

    assign out_port = data_q;
`endif

endmodule

// File: tb/tb_nios_leds_ctrl.sv
// Scoreboard bench for nios_leds_ctrl (WIDTH=4, RESET_VALUE=4'hA).
module tb_nios_leds_ctrl;

    localparam int         WIDTH    = 4;
    localparam int         PERIOD_W = 24;
    localparam logic [3:0] RV       = 4'hA;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    nios_leds_ctrl #(
        .WIDTH       (WIDTH),
        .PERIOD_W    (PERIOD_W),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3;
        exp_q.push_back({28'd0, RV});
        e = exp_q.pop_front();
        checks++;
        if ({28'd0, out_port} !== e) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", out_port, e);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = i[2:0];
            exp_q.push_back(i == 0 ? {28'd0, RV} : 32'd0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL reset_read a=%0d got=%h exp=%h", i, readdata, e);
            end
        end
    endtask

    task automatic test_set_clear;
        logic [2:0]  wa[7];
        logic [31:0] wv[7];
        logic [3:0]  wo[7];
        wa = '{3'd0, 3'd4, 3'd5, 3'd0, 3'd6, 3'd7, 3'd4};
        wv = '{32'h5, 32'h8, 32'h1, 32'hFFFF_FFF3,
               32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF0};
        wo = '{4'h5, 4'hD, 4'hC, 4'h3, 4'h3, 4'h3, 4'h3};
        for (int i = 0; i < 7; i++) begin
            bus_write(wa[i], wv[i]);
            exp_q.push_back({28'd0, wo[i]});
            e = exp_q.pop_front();
            checks++;
            if ({28'd0, out_port} !== e) begin
                errors++;
                $display("FAIL setclr_out step=%0d got=%h exp=%h",
                         i, out_port, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            address = (i == 0) ? 3'd0 : (i == 1 ? 3'd4 : 3'd5);
            exp_q.push_back(i == 0 ? 32'h3 : 32'h0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL setclr_read a=%0d got=%h exp=%h",
                         address, readdata, e);
            end
        end
    endtask

`ifdef NIOS_LEDS_BLINK_EN
    task automatic test_blink;
        bus_write(3'd0, 32'hF);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'h3);
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(((k / 3) % 2) ? 32'hF : 32'hC);
            exp_q.push_back(((k / 3) % 2) ? 32'h3 : 32'h2);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            address = 3'd3;
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({28'd0, out_port} !== e) begin
                errors++;
                $display("FAIL blink_out k=%0d got=%h exp=%h", k, out_port, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL blink_status k=%0d got=%h exp=%h",
                         k, readdata, e);
            end
        end
        address = 3'd1;
        #1;
        checks++;
        if (readdata !== 32'h3) begin
            errors++;
            $display("FAIL mode_read got=%h exp=3", readdata);
        end
        address = 3'd2;
        #1;
        checks++;
        if (readdata !== 32'h3) begin
            errors++;
            $display("FAIL period_read got=%h exp=3", readdata);
        end
    endtask

    task automatic test_period_wr_wins;
        bus_write(3'd2, 32'h3);
        repeat (2) @(posedge clk);
        bus_write(3'd2, 32'h5);
        for (int k = 0; k < 10; k++)
            exp_q.push_back(k < 5 ? 32'hC : 32'hF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({28'd0, out_port} !== e) begin
                errors++;
                $display("FAIL wrwins_out k=%0d got=%h exp=%h", k, out_port, e);
            end
        end
    endtask

    task automatic test_period_one;
        bus_write(3'd1, 32'hF);
        bus_write(3'd2, 32'h1);
        for (int k = 0; k < 6; k++)
            exp_q.push_back((k % 2) ? 32'hF : 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({28'd0, out_port} !== e) begin
                errors++;
                $display("FAIL p1_out k=%0d got=%h exp=%h", k, out_port, e);
            end
        end
    endtask

    task automatic test_reset_async;
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'h3);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (out_port !== 4'hF) begin
            errors++;
            $display("FAIL pre_reset_out got=%h exp=f", out_port);
        end
        reset = 1'b1;
        #1;
        exp_q.push_back({28'd0, RV});
        e = exp_q.pop_front();
        checks++;
        if ({28'd0, out_port} !== e) begin
            errors++;
            $display("FAIL async_reset_out got=%h exp=%h", out_port, e);
        end
        for (int i = 1; i < 4; i++) begin
            address = i[2:0];
            exp_q.push_back(32'd0);
            #0.5;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL async_reset_read a=%0d got=%h exp=%h",
                         i, readdata, e);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask
`else
    task automatic test_no_blink;
        bus_write(3'd1, 32'hF);
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, 32'h6);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(32'h6);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({28'd0, out_port} !== e) begin
                errors++;
                $display("FAIL noblink_out k=%0d got=%h exp=%h", k, out_port, e);
            end
        end
        for (int i = 1; i < 4; i++) begin
            address = i[2:0];
            exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL noblink_read a=%0d got=%h exp=%h",
                         i, readdata, e);
            end
        end
    endtask
`endif

    initial begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        test_reset;
        test_set_clear;
`ifdef NIOS_LEDS_BLINK_EN
        test_blink;
        test_period_wr_wins;
        test_period_one;
        test_reset_async;
`else
        test_no_blink;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
